// File: rtl/gs_frame_buffer_if.sv
// Host-write, swap-control and driver-read signals of the grayscale frame buffer.
// master = host/driver side, slave = frame buffer side.
interface gs_frame_buffer_if #(
   parameter int unsigned GS_BITS = 12
);
   logic               wr_valid;
   logic               wr_ready;
   logic [2:0]         wr_row;
   logic [5:0]         wr_chan;
   logic [GS_BITS-1:0] wr_data;
   logic               wr_drop;
   logic               swap_req;
   logic               swap_pending;
   logic               swap_done;
   logic               frame_end;
   logic [2:0]         rd_row;
   logic [9:0]         rd_bit;
   logic               rd_data;
   logic               busy;

   modport master (
      output wr_valid, wr_row, wr_chan, wr_data, swap_req, frame_end, rd_row, rd_bit,
      input  wr_ready, wr_drop, swap_pending, swap_done, rd_data, busy
   );

   modport slave (
      input  wr_valid, wr_row, wr_chan, wr_data, swap_req, frame_end, rd_row, rd_bit,
      output wr_ready, wr_drop, swap_pending, swap_done, rd_data, busy
   );
endinterface

// File: rtl/gs_frame_buffer.sv
// Double-buffered grayscale store for the LED panel: host writes the back bank,
// the LED driver streams the front bank bit-serially; banks swap on frame boundaries.
module gs_frame_buffer #(
   parameter int unsigned ROWS     = 6,
   parameter int unsigned CHANNELS = 48,
   parameter int unsigned GS_BITS  = 12
) (
   input  logic              clock,
   input  logic              reset_n,
   gs_frame_buffer_if.slave  bus
);
   localparam int unsigned DEPTH    = ROWS * CHANNELS;
   localparam int unsigned ROW_BITS = CHANNELS * GS_BITS;
   localparam int unsigned AW       = $clog2(DEPTH);
   localparam int unsigned PW       = $clog2(GS_BITS);
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   typedef enum logic [1:0] {
      ST_CLEAR,
      ST_IDLE,
      ST_SWAP_WAIT
   } state_t;

   state_t          state, state_n;
   logic            front_sel, front_sel_n;
   logic [AW-1:0]   clr_addr, clr_addr_n;
   logic            swap_now;

   logic [GS_BITS-1:0] bank0 [DEPTH];
   logic [GS_BITS-1:0] bank1 [DEPTH];

   // Write decode
   logic            wr_accept;
   logic            wr_in_range;
   logic [AW-1:0]   wr_addr;

   always_comb begin
      wr_in_range = (32'(bus.wr_row) < ROWS) && (32'(bus.wr_chan) < CHANNELS);
      wr_accept   = bus.wr_valid && bus.wr_ready;
      wr_addr     = '0;
      if (wr_in_range)
         wr_addr = AW'(32'(bus.wr_row) * CHANNELS + 32'(bus.wr_chan));
   end

   // Read decode: the bit stream runs from the MSB of the highest channel down
   logic [9:0]         rd_q;
   logic [9:0]         rd_r;
   logic [31:0]        rd_chan;
   logic               rd_in_range;
   logic [AW-1:0]      rd_addr;
   logic [PW-1:0]      rd_pos;
   logic [GS_BITS-1:0] rd_word;
   logic               rd_bit_n;

   always_comb begin
      rd_q        = bus.rd_bit / 10'(GS_BITS);
      rd_r        = bus.rd_bit % 10'(GS_BITS);
      rd_chan     = (CHANNELS - 1) - 32'(rd_q);
      rd_in_range = (32'(bus.rd_row) < ROWS) && (32'(bus.rd_bit) < ROW_BITS);
      rd_addr     = '0;
      rd_pos      = '0;
      if (rd_in_range) begin
         rd_addr = AW'(32'(bus.rd_row) * CHANNELS + rd_chan);
         rd_pos  = PW'((GS_BITS - 1) - 32'(rd_r));
      end
      rd_word  = front_sel ? bank1[rd_addr] : bank0[rd_addr];
      rd_bit_n = rd_in_range && (state != ST_CLEAR) && rd_word[rd_pos];
   end

   // Next-state logic
   always_comb begin
      state_n     = state;
      front_sel_n = front_sel;
      clr_addr_n  = clr_addr;
      swap_now    = 1'b0;
      unique case (state)
         ST_CLEAR: begin
            clr_addr_n = clr_addr + AW'(1);
            if (clr_addr == LAST_ADDR) begin
               clr_addr_n = '0;
               state_n    = ST_IDLE;
            end
         end
         ST_IDLE: begin
            // A request coinciding with the frame boundary swaps at once
            if (bus.swap_req) begin
               if (bus.frame_end)
                  swap_now = 1'b1;
               else
                  state_n = ST_SWAP_WAIT;
            end
         end
         ST_SWAP_WAIT: begin
            if (bus.frame_end) begin
               swap_now = 1'b1;
               state_n  = ST_IDLE;
            end
         end
         default: state_n = ST_CLEAR;
      endcase
      if (swap_now)
         front_sel_n = ~front_sel;
   end

   always_comb begin
      bus.wr_ready     = (state == ST_IDLE);
      bus.swap_pending = (state == ST_SWAP_WAIT);
      bus.busy         = (state == ST_CLEAR);
      bus.swap_done    = swap_now && reset_n;
   end

   logic wr_drop_q;
   logic rd_data_q;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state     <= ST_CLEAR;
         front_sel <= 1'b0;
         clr_addr  <= '0;
         wr_drop_q <= 1'b0;
         rd_data_q <= 1'b0;
      end else begin
         state     <= state_n;
         front_sel <= front_sel_n;
         clr_addr  <= clr_addr_n;
         wr_drop_q <= wr_accept && !wr_in_range;
         rd_data_q <= rd_bit_n;
      end
   end

   assign bus.wr_drop = wr_drop_q;
   assign bus.rd_data = rd_data_q;

   // Writes target the bank selected before any same-edge toggle, so they never hit the display bank
   always_ff @(posedge clock) begin
      if (reset_n) begin
         if (state == ST_CLEAR) begin
            bank0[clr_addr] <= '0;
            bank1[clr_addr] <= '0;
         end else if (wr_accept && wr_in_range) begin
            if (front_sel)
               bank0[wr_addr] <= bus.wr_data;
            else
               bank1[wr_addr] <= bus.wr_data;
         end
      end
   end
endmodule

// File: tb/tb_gs_frame_buffer.sv
// Self-checking bench for gs_frame_buffer against a bank/row/channel reference model.
module tb_gs_frame_buffer;
   localparam int ROWS = 6;
   localparam int CH   = 48;
   localparam int GB   = 12;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   gs_frame_buffer_if #(.GS_BITS(GB)) bus ();

   gs_frame_buffer #(
      .ROWS(ROWS),
      .CHANNELS(CH),
      .GS_BITS(GB)
   ) dut (
      .clock(clock),
      .reset_n(reset_n),
      .bus(bus.slave)
   );

   int checks = 0;
   int errors = 0;

   logic [11:0] mdl [2][8][CH];
   int          mfront;
   bit          mpending;

   // Row image is the channels laid end to end, highest channel first, MSB first
   function automatic logic exp_bit(int bank, int row, int b);
      int k = 0;
      if (row >= ROWS || b >= CH * GB) return 1'b0;
      for (int ch = CH - 1; ch >= 0; ch--)
         for (int p = GB - 1; p >= 0; p--) begin
            if (k == b) return mdl[bank][row][ch][p];
            k++;
         end
      return 1'b0;
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      bus.wr_valid  = 1'b0;
      bus.wr_row    = '0;
      bus.wr_chan   = '0;
      bus.wr_data   = '0;
      bus.swap_req  = 1'b0;
      bus.frame_end = 1'b0;
      bus.rd_row    = '0;
      bus.rd_bit    = '0;
   endtask

   task automatic model_clear();
      for (int b = 0; b < 2; b++)
         for (int r = 0; r < 8; r++)
            for (int c = 0; c < CH; c++)
               mdl[b][r][c] = '0;
      mfront   = 0;
      mpending = 1'b0;
   endtask

   task automatic wait_clear(bit poke_swap);
      for (int i = 0; i < 288; i++) begin
         bus.swap_req = poke_swap && (i == 100);
         bus.rd_row   = 3'd5;
         bus.rd_bit   = 10'(564 + (i % 12));
         #3;
         checks++;
         if (bus.busy !== 1'b1 || bus.wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL clear_busy cyc %0d: busy=%b ready=%b, want busy=1 ready=0", i, bus.busy, bus.wr_ready);
         end
         checks++;
         if (bus.swap_pending !== 1'b0 || bus.swap_done !== 1'b0) begin
            errors++;
            $display("FAIL clear_swap cyc %0d: pending=%b done=%b, want 0 0", i, bus.swap_pending, bus.swap_done);
         end
         tick();
         checks++;
         if (bus.rd_data !== 1'b0) begin
            errors++;
            $display("FAIL clear_rd cyc %0d: rd_data=%b want 0", i, bus.rd_data);
         end
      end
      bus.swap_req = 1'b0;
      checks++;
      if (bus.busy !== 1'b0 || bus.wr_ready !== 1'b1) begin
         errors++;
         $display("FAIL clear_end: busy=%b ready=%b, want busy=0 ready=1", bus.busy, bus.wr_ready);
      end
   endtask

   task automatic sweep_rows(int r0, int r1);
      int shown = 0;
      logic e;
      for (int r = r0; r <= r1; r++)
         for (int b = 0; b < 578; b++) begin
            bus.rd_row = 3'(r);
            bus.rd_bit = (b >= 576) ? 10'(1023 - (b - 576)) : 10'(b);
            e = exp_bit(mfront, r, int'(bus.rd_bit));
            tick();
            checks++;
            if (bus.rd_data !== e) begin
               errors++;
               if (shown < 8)
                  $display("FAIL sweep row %0d bit %0d: rd_data=%b want %b", r, bus.rd_bit, bus.rd_data, e);
               shown++;
            end
         end
   endtask

   task automatic do_write(int r, int c, logic [11:0] d);
      bit oor = (r >= ROWS) || (c >= CH);
      bus.wr_valid = 1'b1;
      bus.wr_row   = 3'(r);
      bus.wr_chan  = 6'(c);
      bus.wr_data  = d;
      #3;
      checks++;
      if (bus.wr_ready !== 1'b1) begin
         errors++;
         $display("FAIL wr_ready row %0d chan %0d: got %b want 1", r, c, bus.wr_ready);
      end
      tick();
      bus.wr_valid = 1'b0;
      checks++;
      if (bus.wr_drop !== oor) begin
         errors++;
         $display("FAIL wr_drop row %0d chan %0d: got %b want %b", r, c, bus.wr_drop, oor);
      end
      if (!oor) mdl[1 - mfront][r][c] = d;
   endtask

   task automatic do_swap_wait(int gap, bit second_req);
      bus.swap_req = 1'b1;
      #3;
      checks++;
      if (bus.swap_done !== 1'b0) begin
         errors++;
         $display("FAIL swap_req_done: got %b want 0", bus.swap_done);
      end
      tick();
      bus.swap_req = 1'b0;
      for (int i = 0; i < gap; i++) begin
         bus.swap_req = second_req && (i == 3);
         #3;
         checks++;
         if (bus.swap_pending !== 1'b1 || bus.wr_ready !== 1'b0 || bus.swap_done !== 1'b0) begin
            errors++;
            $display("FAIL swap_wait cyc %0d: pending=%b ready=%b done=%b, want 1 0 0",
                     i, bus.swap_pending, bus.wr_ready, bus.swap_done);
         end
         tick();
         bus.swap_req = 1'b0;
      end
      bus.frame_end = 1'b1;
      #3;
      checks++;
      if (bus.swap_done !== 1'b1 || bus.swap_pending !== 1'b1) begin
         errors++;
         $display("FAIL swap_fire: done=%b pending=%b, want 1 1", bus.swap_done, bus.swap_pending);
      end
      tick();
      bus.frame_end = 1'b0;
      mfront = 1 - mfront;
      checks++;
      if (bus.swap_pending !== 1'b0 || bus.wr_ready !== 1'b1 || bus.swap_done !== 1'b0) begin
         errors++;
         $display("FAIL swap_after: pending=%b ready=%b done=%b, want 0 1 0",
                  bus.swap_pending, bus.wr_ready, bus.swap_done);
      end
      // stray frame boundary with nothing pending
      bus.frame_end = 1'b1;
      #3;
      checks++;
      if (bus.swap_done !== 1'b0) begin
         errors++;
         $display("FAIL stray_frame_end: swap_done=%b want 0", bus.swap_done);
      end
      tick();
      bus.frame_end = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset_n = 1'b0;
      tick();
      checks++;
      if (bus.busy !== 1'b1 || bus.wr_ready !== 1'b0 || bus.swap_pending !== 1'b0 ||
          bus.wr_drop !== 1'b0 || bus.rd_data !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: busy=%b ready=%b pending=%b drop=%b rd=%b, want 1 0 0 0 0",
                  bus.busy, bus.wr_ready, bus.swap_pending, bus.wr_drop, bus.rd_data);
      end
      tick();
      reset_n = 1'b1;
      model_clear();
      wait_clear(1'b0);
      sweep_rows(0, 7);
   endtask

   task automatic test_write_swap();
      logic [23:0] pat = 24'b0000_1111_1111_0000_1111_1111;
      do_write(0, 47, 12'h0FF);
      do_write(0, 46, 12'h0FF);
      do_swap_wait(9, 1'b0);
      for (int b = 0; b < 24; b++) begin
         bus.rd_row = 3'd0;
         bus.rd_bit = 10'(b);
         tick();
         checks++;
         if (bus.rd_data !== pat[23 - b]) begin
            errors++;
            $display("FAIL pattern bit %0d: rd_data=%b want %b", b, bus.rd_data, pat[23 - b]);
         end
      end
      sweep_rows(0, 1);
   endtask

   task automatic test_drop();
      do_write(6, 0, 12'hABC);
      tick();
      checks++;
      if (bus.wr_drop !== 1'b0) begin
         errors++;
         $display("FAIL drop_pulse_width: wr_drop=%b want 0", bus.wr_drop);
      end
      do_write(2, 50, 12'h555);
      do_write(7, 63, 12'hFFF);
      do_write(4, 20, 12'h9A5);
      do_swap_wait(2, 1'b0);
      sweep_rows(0, 7);
   endtask

   task automatic test_coincident();
      bus.wr_valid  = 1'b1;
      bus.wr_row    = 3'd3;
      bus.wr_chan   = 6'd10;
      bus.wr_data   = 12'hF0F;
      bus.swap_req  = 1'b1;
      bus.frame_end = 1'b1;
      #3;
      checks++;
      if (bus.swap_done !== 1'b1 || bus.swap_pending !== 1'b0) begin
         errors++;
         $display("FAIL coinc_done: done=%b pending=%b, want 1 0", bus.swap_done, bus.swap_pending);
      end
      tick();
      idle_inputs();
      mdl[1 - mfront][3][10] = 12'hF0F;
      mfront = 1 - mfront;
      checks++;
      if (bus.swap_pending !== 1'b0 || bus.wr_ready !== 1'b1) begin
         errors++;
         $display("FAIL coinc_after: pending=%b ready=%b, want 0 1", bus.swap_pending, bus.wr_ready);
      end
      sweep_rows(3, 4);
   endtask

   task automatic test_double_req();
      do_write(2, 5, 12'h3C3);
      do_write(0, 0, 12'h801);
      do_swap_wait(6, 1'b1);
      sweep_rows(0, 2);
   endtask

   task automatic test_read_across_swap();
      logic [11:0] f = mdl[mfront][1][39];
      logic e;
      do_write(1, 39, f ^ 12'h080);
      bus.swap_req = 1'b1;
      tick();
      bus.swap_req = 1'b0;
      for (int i = 0; i < 12; i++) begin
         bus.rd_row    = 3'd1;
         bus.rd_bit    = 10'd100;
         bus.frame_end = (i == 5);
         e = exp_bit(mfront, 1, 100);
         #3;
         checks++;
         if (bus.swap_done !== bus.frame_end) begin
            errors++;
            $display("FAIL xswap_done cyc %0d: got %b want %b", i, bus.swap_done, bus.frame_end);
         end
         tick();
         if (i == 5) mfront = 1 - mfront;
         bus.frame_end = 1'b0;
         checks++;
         if (bus.rd_data !== e) begin
            errors++;
            $display("FAIL xswap_rd cyc %0d: rd_data=%b want %b", i, bus.rd_data, e);
         end
      end
   endtask

   task automatic test_random();
      int  row, ch, rr, rb;
      bit  wv, sr, fe, acc, oor, drop, swap_now;
      logic [11:0] d;
      logic e;
      for (int i = 0; i < 800; i++) begin
         wv  = ($urandom_range(0, 3) != 0);
         row = $urandom_range(0, 6);
         ch  = $urandom_range(0, 49);
         d   = 12'($urandom);
         sr  = ($urandom_range(0, 15) == 0);
         fe  = ($urandom_range(0, 7) == 0);
         rr  = $urandom_range(0, 6);
         rb  = $urandom_range(0, 600);
         bus.wr_valid  = wv;
         bus.wr_row    = 3'(row);
         bus.wr_chan   = 6'(ch);
         bus.wr_data   = d;
         bus.swap_req  = sr;
         bus.frame_end = fe;
         bus.rd_row    = 3'(rr);
         bus.rd_bit    = 10'(rb);
         swap_now = fe && (mpending || sr);
         acc  = wv && !mpending;
         oor  = (row >= ROWS) || (ch >= CH);
         drop = acc && oor;
         e    = exp_bit(mfront, rr, rb);
         #3;
         checks++;
         if (bus.wr_ready !== !mpending || bus.swap_pending !== mpending || bus.swap_done !== swap_now) begin
            errors++;
            $display("FAIL rnd_ctrl cyc %0d: ready=%b pending=%b done=%b, want %b %b %b",
                     i, bus.wr_ready, bus.swap_pending, bus.swap_done, !mpending, mpending, swap_now);
         end
         tick();
         if (acc && !oor) mdl[1 - mfront][row][ch] = d;
         if (swap_now) begin
            mfront   = 1 - mfront;
            mpending = 1'b0;
         end else if (sr && !mpending) begin
            mpending = 1'b1;
         end
         checks++;
         if (bus.rd_data !== e || bus.wr_drop !== drop) begin
            errors++;
            $display("FAIL rnd_data cyc %0d: rd_data=%b drop=%b, want %b %b", i, bus.rd_data, bus.wr_drop, e, drop);
         end
      end
      idle_inputs();
      if (mpending) begin
         bus.frame_end = 1'b1;
         tick();
         bus.frame_end = 1'b0;
         mfront   = 1 - mfront;
         mpending = 1'b0;
      end
      sweep_rows(0, 5);
   endtask

   task automatic test_reset_mid_swap();
      logic e;
      // put data in the display bank so the clear has something to hide
      bus.wr_valid  = 1'b1;
      bus.wr_row    = 3'd5;
      bus.wr_chan   = 6'd0;
      bus.wr_data   = 12'hFFF;
      bus.swap_req  = 1'b1;
      bus.frame_end = 1'b1;
      tick();
      idle_inputs();
      bus.swap_req = 1'b1;
      tick();
      bus.swap_req = 1'b0;
      tick();
      checks++;
      if (bus.swap_pending !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset_pending: got %b want 1", bus.swap_pending);
      end
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      model_clear();
      checks++;
      if (bus.swap_pending !== 1'b0 || bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset: pending=%b busy=%b, want 0 1", bus.swap_pending, bus.busy);
      end
      wait_clear(1'b1);
      bus.frame_end = 1'b1;
      #3;
      checks++;
      if (bus.swap_done !== 1'b0) begin
         errors++;
         $display("FAIL post_clear_frame_end: swap_done=%b want 0", bus.swap_done);
      end
      tick();
      bus.frame_end = 1'b0;
      checks++;
      if (bus.swap_pending !== 1'b0) begin
         errors++;
         $display("FAIL post_clear_pending: got %b want 0", bus.swap_pending);
      end
      // front bank must be bank 0 again: a write must stay invisible until a swap
      do_write(0, 0, 12'hFFF);
      for (int b = 564; b < 576; b++) begin
         bus.rd_row = 3'd0;
         bus.rd_bit = 10'(b);
         e = exp_bit(mfront, 0, b);
         tick();
         checks++;
         if (bus.rd_data !== e) begin
            errors++;
            $display("FAIL post_reset_front bit %0d: rd_data=%b want %b", b, bus.rd_data, e);
         end
      end
      do_swap_wait(1, 1'b0);
      sweep_rows(0, 0);
      sweep_rows(5, 5);
   endtask

   initial begin
      idle_inputs();
      model_clear();
      test_reset();
      test_write_swap();
      test_drop();
      test_coincident();
      test_double_req();
      test_read_across_swap();
      test_random();
      test_reset_mid_swap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
